// File: rtl/jtkicker_pkg.sv
// Shared definitions for the jtkicker object ROM path: SDRAM address width,
// slot FSM states and per-variant object ROM offsets in SDRAM.
package jtkicker_pkg;

    localparam int SDRAM_AW = 22;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA
    } slot_state_t;

    // 16-bit word offsets of the object ROM region for each game variant
    localparam logic [SDRAM_AW-1:0] KICKER_OBJ_OFFSET  = 22'h08_0000;
    localparam logic [SDRAM_AW-1:0] SHAOLIN_OBJ_OFFSET = 22'h0A_0000;
    localparam logic [SDRAM_AW-1:0] YIEAR_OBJ_OFFSET   = 22'h0C_0000;

endpackage

// File: rtl/jtkicker_objrom_slot.sv
// Object ROM slot: turns 32-bit word requests into two-halfword SDRAM bursts
// and keeps the last fetched word in a one-entry tag cache.
module jtkicker_objrom_slot
    import jtkicker_pkg::*;
#(
    parameter int                  AW     = 14,
    parameter logic [SDRAM_AW-1:0] OFFSET = KICKER_OBJ_OFFSET
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic                slot_cs,
    input  logic [AW-1:0]       slot_addr,
    output logic                slot_ok,
    output logic [31:0]         slot_dout,
    output logic                sdram_req,
    output logic [SDRAM_AW-1:0] sdram_addr,
    input  logic                sdram_ack,
    input  logic                sdram_dst,
    input  logic [15:0]         data_read
);

    slot_state_t   state, state_nx;
    logic [AW-1:0] pend;
    logic [AW-1:0] tag;
    logic          valid;
    logic          no_cache;
    logic          cnt;
    logic [15:0]   buf_lo;
    logic          hit;
    logic          capture;
    logic          last;

    // Word address -> halfword address, wrapping modulo 2^SDRAM_AW
    function automatic logic [SDRAM_AW-1:0] burst_addr(input logic [AW-1:0] a);
        logic [SDRAM_AW-1:0] half;
        half = SDRAM_AW'({a, 1'b0});
        return OFFSET + half;
    endfunction

    assign hit     = valid && (tag == slot_addr);
    // A dst in the ack cycle itself belongs to the burst being accepted
    assign capture = sdram_dst && ((state == DATA) || (state == REQ && sdram_ack));
    assign last    = capture && cnt;
    assign slot_ok = slot_cs && hit && !downloading && (state == IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (slot_cs && !downloading && !hit) state_nx = REQ;
            REQ:  if (sdram_ack) state_nx = DATA;
            DATA: if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            valid      <= 1'b0;
            tag        <= '0;
            pend       <= '0;
            slot_dout  <= '0;
            cnt        <= 1'b0;
            buf_lo     <= '0;
            no_cache   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == REQ) begin
                pend       <= slot_addr;
                sdram_addr <= burst_addr(slot_addr);
                sdram_req  <= 1'b1;
                cnt        <= 1'b0;
                no_cache   <= 1'b0;
            end
            if (state == REQ && sdram_ack) sdram_req <= 1'b0;
            if (capture) begin
                cnt <= ~cnt;
                if (!cnt) buf_lo <= data_read;
            end
            if (last) begin
                slot_dout <= {data_read, buf_lo};
                tag       <= pend;
            end
            // A burst that overlapped a download is drained but never trusted
            if (downloading) begin
                valid <= 1'b0;
                if (state != IDLE) no_cache <= 1'b1;
            end else if (last) begin
                valid <= !no_cache;
            end
        end
    end

endmodule

// File: tb/tb_jtkicker_objrom_slot.sv
// Bench for jtkicker_objrom_slot: directed scenarios plus randomized accesses
// checked against a one-entry cache model; a second instance covers address wrap.
module tb_jtkicker_objrom_slot;

    localparam logic [21:0] OFF_MAIN = 22'h08_0000;
    localparam logic [21:0] OFF_WRAP = 22'h3F_FFFE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic        slot_cs = 1'b0;
    logic [13:0] slot_addr = '0;
    logic        sdram_ack = 1'b0;
    logic        sdram_dst = 1'b0;
    logic [15:0] data_read = '0;

    logic        slot_ok, w_slot_ok;
    logic [31:0] slot_dout, w_slot_dout;
    logic        sdram_req, w_sdram_req;
    logic [21:0] sdram_addr, w_sdram_addr;

    int checks = 0;
    int failures = 0;

    // Reference cache contents
    bit          m_valid = 1'b0;
    logic [13:0] m_tag = '0;
    logic [31:0] m_data = '0;

    jtkicker_objrom_slot #(.AW(14), .OFFSET(OFF_MAIN)) u_dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_ok(slot_ok), .slot_dout(slot_dout),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .sdram_dst(sdram_dst), .data_read(data_read)
    );

    jtkicker_objrom_slot #(.AW(14), .OFFSET(OFF_WRAP)) u_wrap (
        .clk(clk), .rst(rst), .downloading(downloading),
        .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_ok(w_slot_ok), .slot_dout(w_slot_dout),
        .sdram_req(w_sdram_req), .sdram_addr(w_sdram_addr),
        .sdram_ack(sdram_ack), .sdram_dst(sdram_dst), .data_read(data_read)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] exp_addr(input logic [13:0] a, input logic [21:0] off);
        int unsigned s;
        s = (int'(off) + 2 * int'(a)) % (1 << 22);
        return 22'(s);
    endfunction

    function automatic logic exp_ok();
        return slot_cs && !downloading && m_valid && (m_tag == slot_addr);
    endfunction

    // Answer an already-issued request, then update the model
    task automatic serve(input logic [13:0] a, input logic [15:0] lo, input logic [15:0] hi,
                         input int gap_ack, input bit ack_dst, input int gap1,
                         input int gap2, input bit dl_pulse);
        bit nocache;
        nocache = 1'b0;
        for (int i = 0; i < gap_ack; i++) begin
            sdram_dst = 1'($urandom_range(0, 1));
            data_read = 16'($urandom);
            tick();
            sdram_dst = 1'b0;
            chk("req_hold", sdram_req, 1);
            chk("busy_ok", slot_ok, 0);
        end
        sdram_ack = 1'b1;
        sdram_dst = ack_dst;
        data_read = lo;
        tick();
        sdram_ack = 1'b0;
        sdram_dst = 1'b0;
        chk("ack_drop", sdram_req, 0);
        chk("ack_wrap_drop", w_sdram_req, 0);
        if (dl_pulse) begin
            downloading = 1'b1;
            #1;
            chk("dl_busy_ok", slot_ok, 0);
            tick();
            downloading = 1'b0;
            nocache = 1'b1;
            m_valid = 1'b0;
        end
        if (!ack_dst) begin
            for (int i = 0; i < gap1; i++) begin
                tick();
                chk("busy_ok", slot_ok, 0);
            end
            sdram_dst = 1'b1;
            data_read = lo;
            tick();
            sdram_dst = 1'b0;
        end
        for (int i = 0; i < gap2; i++) begin
            tick();
            chk("busy_ok", slot_ok, 0);
        end
        sdram_dst = 1'b1;
        data_read = hi;
        tick();
        sdram_dst = 1'b0;
        if (!nocache) begin
            m_valid = 1'b1;
            m_tag   = a;
            m_data  = {hi, lo};
            chk("fill_dout", slot_dout, m_data);
            chk("wrap_dout", w_slot_dout, m_data);
        end
        chk("fill_ok", slot_ok, exp_ok());
        chk("wrap_fill_ok", w_slot_ok, exp_ok());
        slot_cs = 1'b0;
    endtask

    task automatic access(input logic [13:0] a, input logic [15:0] lo, input logic [15:0] hi,
                          input int gap_ack, input bit ack_dst, input int gap1,
                          input int gap2, input bit drop_cs, input bit dl_pulse);
        slot_cs   = 1'b1;
        slot_addr = a;
        #1;
        if (m_valid && m_tag == a) begin
            chk("hit_ok", slot_ok, 1);
            chk("hit_dout", slot_dout, m_data);
            tick();
            chk("hit_noreq", sdram_req, 0);
            slot_cs = 1'b0;
        end else begin
            chk("miss_ok", slot_ok, 0);
            tick();
            chk("req", sdram_req, 1);
            chk("req_addr", sdram_addr, exp_addr(a, OFF_MAIN));
            chk("wrap_addr", w_sdram_addr, exp_addr(a, OFF_WRAP));
            if (drop_cs) slot_cs = 1'b0;
            serve(a, lo, hi, gap_ack, ack_dst, gap1, gap2, dl_pulse);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ok", slot_ok, 0);
        chk("rst_req", sdram_req, 0);
        chk("rst_addr", sdram_addr, 0);
        chk("rst_dout", slot_dout, 0);
        rst = 1'b0;
        tick();

        // First miss and the hit that follows
        access(14'h0123, 16'hBEEF, 16'hDEAD, 3, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("miss_addr_abs", sdram_addr, 22'h080246);
        chk("miss_dout_abs", slot_dout, 32'hDEADBEEF);
        tick();
        access(14'h0123, 16'h0, 16'h0, 0, 1'b0, 0, 0, 1'b0, 1'b0);

        // Halfword address wraps past the top of SDRAM
        access(14'h0001, 16'h4321, 16'h8765, 1, 1'b1, 0, 1, 1'b0, 1'b0);
        chk("wrap_zero", w_sdram_addr, 22'h000000);

        // Address changes between ack and the first dst
        slot_cs   = 1'b1;
        slot_addr = 14'h0010;
        tick();
        chk("chg_req", sdram_req, 1);
        chk("chg_addr0", sdram_addr, 22'h080020);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        slot_addr = 14'h0011;
        sdram_dst = 1'b1;
        data_read = 16'h1111;
        tick();
        data_read = 16'h2222;
        tick();
        sdram_dst = 1'b0;
        m_valid = 1'b1;
        m_tag   = 14'h0010;
        m_data  = 32'h2222_1111;
        chk("chg_ok", slot_ok, 0);
        chk("chg_dout", slot_dout, 32'h2222_1111);
        tick();
        chk("chg_req2", sdram_req, 1);
        chk("chg_addr1", sdram_addr, 22'h080022);
        serve(14'h0011, 16'h3333, 16'h4444, 2, 1'b0, 1, 0, 1'b0);

        // Download invalidates the cache and blocks requests
        access(14'h0005, 16'h5555, 16'h6666, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        slot_cs     = 1'b1;
        slot_addr   = 14'h0005;
        downloading = 1'b1;
        #1;
        chk("dl_ok", slot_ok, 0);
        tick();
        m_valid = 1'b0;
        chk("dl_noreq", sdram_req, 0);
        tick();
        chk("dl_noreq2", sdram_req, 0);
        downloading = 1'b0;
        slot_cs     = 1'b0;
        access(14'h0005, 16'h7777, 16'h8888, 1, 1'b0, 0, 0, 1'b0, 1'b0);

        // Download during a burst: drained, not cached, so the next access refetches
        access(14'h0030, 16'h9999, 16'hAAAA, 1, 1'b0, 1, 0, 1'b0, 1'b1);
        tick();
        access(14'h0030, 16'hBBBB, 16'hCCCC, 0, 1'b0, 0, 0, 1'b0, 1'b0);

        // Reset after the first halfword, then a stray dst
        slot_cs   = 1'b1;
        slot_addr = 14'h0020;
        tick();
        chk("rmid_req", sdram_req, 1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        sdram_dst = 1'b1;
        data_read = 16'hAAAA;
        tick();
        sdram_dst = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_valid = 1'b0;
        chk("rmid_req0", sdram_req, 0);
        chk("rmid_ok", slot_ok, 0);
        chk("rmid_dout", slot_dout, 0);
        sdram_dst = 1'b1;
        data_read = 16'hBAD0;
        tick();
        sdram_dst = 1'b0;
        chk("stray_req", sdram_req, 1);
        chk("stray_addr", sdram_addr, exp_addr(14'h0020, OFF_MAIN));
        serve(14'h0020, 16'h1234, 16'h5678, 0, 1'b0, 0, 0, 1'b0);

        // Randomized traffic over a small address pool
        for (int n = 0; n < 60; n++) begin
            logic [13:0] a;
            int idle;
            a = 14'h0100 + 14'($urandom_range(0, 3));
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) tick();
            if ($urandom_range(0, 7) == 0) begin
                slot_cs     = 1'b1;
                slot_addr   = a;
                downloading = 1'b1;
                #1;
                chk("rnd_dl_ok", slot_ok, 0);
                tick();
                m_valid = 1'b0;
                chk("rnd_dl_noreq", sdram_req, 0);
                downloading = 1'b0;
                slot_cs     = 1'b0;
            end
            access(a, 16'($urandom), 16'($urandom),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), $urandom_range(0, 2),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
